sopc_data_bus: RTL and testbench

//  Parametrised data-side interconnect between the openmips RAM port and NUM_SLV memory-mapped slaves.

---
 rtl/sopc_data_bus_pkg.sv | 15 +
 rtl/sopc_data_bus_if.sv | 41 ++++
 rtl/sopc_addr_decoder.sv | 25 ++
 rtl/sopc_data_bus.sv | 128 ++++++++++++
 tb/tb_sopc_data_bus.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_data_bus_pkg.sv
// Shared types and constants for the SOPC data-side interconnect.
// Holds the bus FSM encoding, the default timeout and the error-data value.
package sopc_data_bus_pkg;

    typedef enum logic [1:0] {
        BusIdle = 2'd0,
        BusBusy = 2'd1,
        BusDone = 2'd2
    } bus_state_e;

    localparam int unsigned DefaultTimeout = 15;
    localparam int unsigned CntW           = 8;
    localparam logic [63:0] BusErrData     = 64'h0;

endpackage

// File: rtl/sopc_data_bus_if.sv
// CPU-side and slave-side signals of the data interconnect.
// master = CPU, slave = memory-mapped slaves, bus = the interconnect itself.
interface sopc_data_bus_if #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
);
    localparam int unsigned SW = DW / 8;

    logic                  m_ce_i;
    logic                  m_we_i;
    logic [SW-1:0]         m_sel_i;
    logic [AW-1:0]         m_addr_i;
    logic [DW-1:0]         m_data_i;
    logic [DW-1:0]         m_data_o;
    logic                  m_stall_o;
    logic                  m_err_o;
    logic [NUM_SLV-1:0]    s_ce_o;
    logic                  s_we_o;
    logic [SW-1:0]         s_sel_o;
    logic [AW-1:0]         s_addr_o;
    logic [DW-1:0]         s_data_o;
    logic [NUM_SLV*DW-1:0] s_data_i;
    logic [NUM_SLV-1:0]    s_ack_i;

    modport master (
        output m_ce_i, m_we_i, m_sel_i, m_addr_i, m_data_i,
        input  m_data_o, m_stall_o, m_err_o
    );

    modport slave (
        input  s_ce_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
        output s_data_i, s_ack_i
    );

    modport bus (
        input  m_ce_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        output m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_sel_o, s_addr_o, s_data_o
    );

endinterface

// File: rtl/sopc_addr_decoder.sv
// Combinational address-window decoder: one-hot hit vector plus any-hit flag.
// Overlapping windows resolve to the lowest slave index.
module sopc_addr_decoder #(
    parameter int unsigned           NUM_SLV  = 4,
    parameter int unsigned           AW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]      addr_i,
    output logic [NUM_SLV-1:0] hit_o,
    output logic               any_hit_o
);

    always_comb begin
        hit_o     = '0;
        any_hit_o = 1'b0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (!any_hit_o && ((addr_i & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW])) begin
                hit_o[k]  = 1'b1;
                any_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect between the CPU RAM port and NUM_SLV slaves.
// One transaction at a time: IDLE latches the request, BUSY waits for ack or timeout, DONE returns.
module sopc_data_bus
    import sopc_data_bus_pkg::*;
#(
    parameter int unsigned           NUM_SLV  = 4,
    parameter int unsigned           AW       = 32,
    parameter int unsigned           DW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h2000_0000, 32'h3000_0000,
                                                 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}},
    parameter int unsigned           TIMEOUT  = DefaultTimeout
) (
    input  logic         clk,
    input  logic         rst,
    sopc_data_bus_if.bus bus_if
);

    localparam int unsigned    SW         = DW / 8;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [DW-1:0]   ErrData    = BusErrData[DW-1:0];

    bus_state_e         state_q;
    logic [CntW-1:0]    cnt_q;
    logic [NUM_SLV-1:0] s_ce_q;
    logic               s_we_q;
    logic [SW-1:0]      s_sel_q;
    logic [AW-1:0]      s_addr_q;
    logic [DW-1:0]      s_data_q;
    logic [DW-1:0]      m_data_q;
    logic               m_err_q;

    logic [NUM_SLV-1:0] hit;
    logic               any_hit;
    logic               ack_hit;
    logic [DW-1:0]      ack_data;
    logic [CntW-1:0]    cnt_inc;

    sopc_addr_decoder #(
        .NUM_SLV  (NUM_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_decoder (
        .addr_i    (bus_if.m_addr_i),
        .hit_o     (hit),
        .any_hit_o (any_hit)
    );

    // s_ce_q is one-hot, so OR-ing the selected slices yields the selected slave's data.
    always_comb begin
        ack_data = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (s_ce_q[k]) begin
                ack_data = ack_data | bus_if.s_data_i[k*DW +: DW];
            end
        end
    end

    assign ack_hit = |(bus_if.s_ack_i & s_ce_q);
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BusIdle;
            cnt_q    <= '0;
            s_ce_q   <= '0;
            s_we_q   <= 1'b0;
            s_sel_q  <= '0;
            s_addr_q <= '0;
            s_data_q <= '0;
            m_data_q <= '0;
            m_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                BusIdle: begin
                    m_data_q <= '0;
                    m_err_q  <= 1'b0;
                    if (bus_if.m_ce_i) begin
                        s_we_q   <= bus_if.m_we_i;
                        s_sel_q  <= bus_if.m_sel_i;
                        s_addr_q <= bus_if.m_addr_i;
                        s_data_q <= bus_if.m_data_i;
                        if (any_hit) begin
                            s_ce_q  <= hit;
                            state_q <= BusBusy;
                        end else begin
                            m_err_q  <= 1'b1;
                            m_data_q <= ErrData;
                            state_q  <= BusDone;
                        end
                    end
                end
                BusBusy: begin
                    cnt_q <= cnt_inc;
                    // An ack in the timeout cycle still counts as a good completion.
                    if (ack_hit) begin
                        s_ce_q   <= '0;
                        m_data_q <= s_we_q ? '0 : ack_data;
                        state_q  <= BusDone;
                    end else if (cnt_inc == TimeoutCnt) begin
                        s_ce_q   <= '0;
                        m_err_q  <= 1'b1;
                        m_data_q <= ErrData;
                        state_q  <= BusDone;
                    end
                end
                BusDone: begin
                    cnt_q    <= '0;
                    m_data_q <= '0;
                    m_err_q  <= 1'b0;
                    state_q  <= BusIdle;
                end
                default: state_q <= BusIdle;
            endcase
        end
    end

    assign bus_if.m_stall_o = (state_q == BusBusy) || ((state_q == BusIdle) && bus_if.m_ce_i);
    assign bus_if.m_data_o  = m_data_q;
    assign bus_if.m_err_o   = m_err_q;
    assign bus_if.s_ce_o    = s_ce_q;
    assign bus_if.s_we_o    = s_we_q;
    assign bus_if.s_sel_o   = s_sel_q;
    assign bus_if.s_addr_o  = s_addr_q;
    assign bus_if.s_data_o  = s_data_q;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Self-checking bench for sopc_data_bus: expectations queued per request, checked in DONE.
// A slave responder acks after a configurable number of BUSY cycles.
module tb_sopc_data_bus;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [NS*AW-1:0] Base = {32'h2000_0000, 32'h0000_0000,
                                         32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] Mask = {32'hF000_0000, 32'hFF00_0000,
                                         32'hF000_0000, 32'hF000_0000};

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [3:0]  ce;
        int          cycles;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    logic [3:0]  ce_seen = '0;
    int          busy_cnt = 0;
    int          ack_after = 0;
    logic [3:0]  ack_force = '0;
    logic [3:0]  resp_ack = '0;
    logic [3:0]  stray_ack = '0;
    logic [31:0] rdata [4];

    always #5 clk = ~clk;

    sopc_data_bus_if #(.NUM_SLV(NS), .AW(AW), .DW(DW)) bus_if ();

    sopc_data_bus #(
        .NUM_SLV  (NS),
        .AW       (AW),
        .DW       (DW),
        .SLV_BASE (Base),
        .SLV_MASK (Mask),
        .TIMEOUT  (15)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    assign bus_if.s_data_i = {rdata[3], rdata[2], rdata[1], rdata[0]};
    assign bus_if.s_ack_i  = resp_ack | stray_ack;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave responder: ack on the ack_after-th BUSY cycle (0 = never).
    always @(posedge clk) begin
        #1;
        if (bus_if.s_ce_o != 4'b0) busy_cnt++;
        else busy_cnt = 0;
        if (ack_after != 0 && busy_cnt == ack_after)
            resp_ack = (ack_force != 4'b0) ? ack_force : bus_if.s_ce_o;
        else
            resp_ack = '0;
    end

    // Monitor: DONE is the first non-stalled cycle after stalled cycles with m_ce_i held.
    always @(negedge clk) begin
        if (rst || !bus_if.m_ce_i) begin
            stall_cnt = 0;
            ce_seen   = '0;
        end else if (bus_if.m_stall_o) begin
            stall_cnt++;
            ce_seen = ce_seen | bus_if.s_ce_o;
        end else if (stall_cnt > 0) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("m_data", bus_if.m_data_o, mon_e.data);
                check_eq("m_err", bus_if.m_err_o, mon_e.err);
                check_eq("s_ce_sel", ce_seen, mon_e.ce);
                check_eq("stall_cycles", stall_cnt, mon_e.cycles);
                check_eq("s_ce_done", bus_if.s_ce_o, 4'b0);
                check_eq("s_we", bus_if.s_we_o, mon_e.we);
                check_eq("s_sel", bus_if.s_sel_o, mon_e.sel);
                check_eq("s_addr", bus_if.s_addr_o, mon_e.addr);
                check_eq("s_data", bus_if.s_data_o, mon_e.wdata);
            end
            stall_cnt = 0;
            ce_seen   = '0;
            done_cnt++;
        end
    end

    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input logic [3:0] force_ack,
                          input logic [3:0] exp_ce, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_cycles);
        exp_t e;
        int   start;
        e.data = exp_data;  e.err = exp_err;  e.ce = exp_ce;  e.cycles = exp_cycles;
        e.we = we;  e.sel = sel;  e.addr = addr;  e.wdata = wdata;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        ack_after        = delay;
        ack_force        = force_ack;
        bus_if.m_we_i    = we;
        bus_if.m_sel_i   = sel;
        bus_if.m_addr_i  = addr;
        bus_if.m_data_i  = wdata;
        bus_if.m_ce_i    = 1'b1;
        start = done_cnt;
        for (int i = 0; i < 40 && done_cnt == start; i++) @(posedge clk);
        check_eq("done_seen", done_cnt != start, 1'b1);
        if (done_cnt == start) sb_q.delete();
        #1;
        bus_if.m_ce_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rbase [3];
        int          slv [3];
        bus_if.m_ce_i   = 1'b0;
        bus_if.m_we_i   = 1'b0;
        bus_if.m_sel_i  = '0;
        bus_if.m_addr_i = '0;
        bus_if.m_data_i = '0;
        for (int i = 0; i < 4; i++) rdata[i] = 32'h0;
        rbase[0] = 32'h0100_0000;  slv[0] = 0;
        rbase[1] = 32'h1000_0000;  slv[1] = 1;
        rbase[2] = 32'h2000_0000;  slv[2] = 3;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_s_ce", bus_if.s_ce_o, 4'b0);
        check_eq("rst_s_we", bus_if.s_we_o, 1'b0);
        check_eq("rst_s_sel", bus_if.s_sel_o, 4'b0);
        check_eq("rst_s_addr", bus_if.s_addr_o, 32'h0);
        check_eq("rst_s_data", bus_if.s_data_o, 32'h0);
        check_eq("rst_m_data", bus_if.m_data_o, 32'h0);
        check_eq("rst_m_err", bus_if.m_err_o, 1'b0);
        check_eq("rst_stall", bus_if.m_stall_o, 1'b0);

        // Read slave1, ack on 3rd BUSY cycle: 4 stalled cycles.
        rdata[1] = 32'hDEAD_BEEF;
        do_txn(1'b0, 4'b1111, 32'h1000_0010, 32'h0, 3, 4'b0, 4'b0010, 32'hDEAD_BEEF, 1'b0, 4);
        // Write slave0, ack in first BUSY cycle.
        rdata[0] = 32'h5555_AAAA;
        do_txn(1'b1, 4'b0011, 32'h0100_0020, 32'h1234_5678, 1, 4'b0, 4'b0001, 32'h0, 1'b0, 2);
        // Unmapped address.
        do_txn(1'b0, 4'b1111, 32'hF000_0000, 32'h0, 1, 4'b0, 4'b0000, 32'h0, 1'b1, 1);
        // Silent slave3 -> timeout after 15 BUSY cycles.
        rdata[3] = 32'hCAFE_F00D;
        do_txn(1'b0, 4'b1111, 32'h2000_0004, 32'h0, 0, 4'b0, 4'b1000, 32'h0, 1'b1, 16);
        // Ack on the 15th BUSY cycle wins over the timeout.
        do_txn(1'b0, 4'b1111, 32'h2000_0008, 32'h0, 15, 4'b0, 4'b1000, 32'hCAFE_F00D, 1'b0, 16);
        // Overlap slave0/slave2: slave0 selected, slave2 ack ignored.
        rdata[2] = 32'h2222_2222;
        do_txn(1'b0, 4'b1111, 32'h0000_0100, 32'h0, 1, 4'b0100, 4'b0001, 32'h0, 1'b1, 16);

        for (int i = 0; i < 6; i++) begin
            int          j;
            int          d;
            logic        we;
            logic [31:0] a;
            logic [31:0] wd;
            j  = $urandom_range(0, 2);
            d  = $urandom_range(1, 6);
            we = 1'($urandom_range(0, 1));
            a  = rbase[j] | ($urandom & 32'h00FF_FFFC);
            wd = $urandom;
            rdata[slv[j]] = $urandom;
            do_txn(we, 4'($urandom_range(1, 15)), a, wd, d, 4'b0, 4'(1 << slv[j]),
                   we ? 32'h0 : rdata[slv[j]], 1'b0, 1 + d);
        end

        // Reset in the 2nd BUSY cycle of a write that slave0 never acks.
        @(posedge clk);
        #1;
        ack_after       = 0;
        ack_force       = '0;
        bus_if.m_we_i   = 1'b1;
        bus_if.m_sel_i  = 4'b1111;
        bus_if.m_addr_i = 32'h0100_0040;
        bus_if.m_data_i = 32'hA5A5_5A5A;
        bus_if.m_ce_i   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("busy_ce", bus_if.s_ce_o, 4'b0001);
        rst           = 1'b1;
        bus_if.m_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst2_s_ce", bus_if.s_ce_o, 4'b0);
        check_eq("rst2_s_we", bus_if.s_we_o, 1'b0);
        check_eq("rst2_s_sel", bus_if.s_sel_o, 4'b0);
        check_eq("rst2_s_addr", bus_if.s_addr_o, 32'h0);
        check_eq("rst2_s_data", bus_if.s_data_o, 32'h0);
        check_eq("rst2_m_err", bus_if.m_err_o, 1'b0);
        check_eq("rst2_stall", bus_if.m_stall_o, 1'b0);
        @(posedge clk);
        #1;
        stray_ack = 4'b0001;
        @(posedge clk);
        #1;
        stray_ack = '0;
        @(negedge clk);
        check_eq("stray_m_data", bus_if.m_data_o, 32'h0);
        check_eq("stray_m_err", bus_if.m_err_o, 1'b0);
        check_eq("stray_s_ce", bus_if.s_ce_o, 4'b0);

        rdata[1] = 32'h0BAD_F00D;
        do_txn(1'b0, 4'b0001, 32'h1000_0100, 32'h0, 2, 4'b0, 4'b0010, 32'h0BAD_F00D, 1'b0, 3);

        repeat (2) @(posedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
